// File: rtl/mt_pkg.sv
// Shared definitions for the hardware thread scheduler.
//   NUM_THREADS : default number of hardware thread contexts
//   TID_W       : default thread-id width, log2(NUM_THREADS)
//   sched_state_t : scheduler FSM state encoding
package mt_pkg;

  localparam int NUM_THREADS = 4;
  localparam int TID_W       = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/thread_sched_if.sv
// Signal bundle between the core front end and the thread scheduler.
//   start/start_mask      : launch a thread group (one-cycle pulse + mask)
//   ready                 : per-thread "may issue this cycle"
//   halt_valid/halt_tid   : a thread retired HALT this cycle
//   issue_stall           : global pipeline freeze
//   issue_valid/issue_tid : registered fetch selection
//   active_mask           : threads launched and not yet halted
//   busy/all_done         : scheduler in RUN / in DONE
// master drives the requests; slave is the scheduler.
interface thread_sched_if #(
  parameter int NUM_THREADS = mt_pkg::NUM_THREADS,
  parameter int TID_W       = mt_pkg::TID_W
);

  logic                   start;
  logic [NUM_THREADS-1:0] start_mask;
  logic [NUM_THREADS-1:0] ready;
  logic                   halt_valid;
  logic [TID_W-1:0]       halt_tid;
  logic                   issue_stall;
  logic                   issue_valid;
  logic [TID_W-1:0]       issue_tid;
  logic [NUM_THREADS-1:0] active_mask;
  logic                   busy;
  logic                   all_done;

  modport master (
    output start, start_mask, ready, halt_valid, halt_tid, issue_stall,
    input  issue_valid, issue_tid, active_mask, busy, all_done
  );

  modport slave (
    input  start, start_mask, ready, halt_valid, halt_tid, issue_stall,
    output issue_valid, issue_tid, active_mask, busy, all_done
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker.
//   req         : request vector, one bit per thread
//   last_tid    : most recently granted thread; search starts just after it
//   grant_valid : at least one request present
//   grant_tid   : first requesting thread strictly after last_tid (wrapping);
//                 equals last_tid when nothing is requested
module rr_pick #(
  parameter int NUM_THREADS = mt_pkg::NUM_THREADS,
  parameter int TID_W       = mt_pkg::TID_W
) (
  input  logic [NUM_THREADS-1:0] req,
  input  logic [TID_W-1:0]       last_tid,
  output logic                   grant_valid,
  output logic [TID_W-1:0]       grant_tid
);

  logic [TID_W-1:0] idx;

  // Offsets 1..NUM_THREADS; the final offset lands back on last_tid itself,
  // so a lone requester is granted again. TID_W-bit addition wraps modulo
  // NUM_THREADS because the thread count is a power of two.
  always_comb begin
    grant_valid = 1'b0;
    grant_tid   = last_tid;
    idx         = '0;
    for (int i = 1; i <= NUM_THREADS; i++) begin
      idx = last_tid + TID_W'(i);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_tid   = idx;
      end
    end
  end

endmodule

// File: rtl/thread_sched.sv
// Hardware thread scheduler: launches a group of thread contexts, issues one
// eligible thread per cycle in round-robin order, retires threads on HALT and
// reports completion.
//   clk : core clock, rising edge
//   rst : synchronous active-high reset
//   bus : thread_sched_if slave port (launch, readiness, halt, stall inputs;
//         issue selection, active mask and status outputs)
module thread_sched #(
  parameter int NUM_THREADS = mt_pkg::NUM_THREADS,
  parameter int TID_W       = mt_pkg::TID_W
) (
  input  logic           clk,
  input  logic           rst,
  thread_sched_if.slave  bus
);

  import mt_pkg::*;

  sched_state_t           state_q, state_d;
  logic                   issue_valid_q, issue_valid_d;
  logic [TID_W-1:0]       issue_tid_q, issue_tid_d;
  logic [TID_W-1:0]       last_tid_q, last_tid_d;
  logic [NUM_THREADS-1:0] active_q, active_d;

  logic [NUM_THREADS-1:0] halt_oh;
  logic [NUM_THREADS-1:0] surviving;
  logic [NUM_THREADS-1:0] eligible;
  logic                   grant_valid;
  logic [TID_W-1:0]       grant_tid;

  // A thread halting this cycle is removed both from the active set and from
  // this cycle's eligible set, so it can never be issued after its HALT.
  assign halt_oh   = bus.halt_valid ? (NUM_THREADS'(1) << bus.halt_tid) : '0;
  assign surviving = active_q & ~halt_oh;
  assign eligible  = surviving & bus.ready;

  rr_pick #(
    .NUM_THREADS (NUM_THREADS),
    .TID_W       (TID_W)
  ) u_pick (
    .req         (eligible),
    .last_tid    (last_tid_q),
    .grant_valid (grant_valid),
    .grant_tid   (grant_tid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      issue_valid_q <= 1'b0;
      issue_tid_q   <= '0;
      last_tid_q    <= TID_W'(NUM_THREADS - 1);
      active_q      <= '0;
    end else begin
      state_q       <= state_d;
      issue_valid_q <= issue_valid_d;
      issue_tid_q   <= issue_tid_d;
      last_tid_q    <= last_tid_d;
      active_q      <= active_d;
    end
  end

  // last_tid restarts at NUM_THREADS-1 on every launch so the first pick
  // searches from thread 0. The all-halted check comes before the stall
  // check: a group finishing during a freeze still drops issue_valid.
  always_comb begin
    state_d       = state_q;
    issue_valid_d = 1'b0;
    issue_tid_d   = issue_tid_q;
    last_tid_d    = last_tid_q;
    active_d      = active_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          if (|bus.start_mask) begin
            state_d    = ST_RUN;
            active_d   = bus.start_mask;
            last_tid_d = TID_W'(NUM_THREADS - 1);
          end else begin
            state_d  = ST_DONE;
            active_d = '0;
          end
        end
      end
      ST_RUN: begin
        active_d = surviving;
        if (surviving == '0) begin
          state_d = ST_DONE;
        end else if (bus.issue_stall) begin
          issue_valid_d = issue_valid_q;
        end else if (grant_valid) begin
          issue_valid_d = 1'b1;
          issue_tid_d   = grant_tid;
          last_tid_d    = grant_tid;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_tid   = issue_tid_q;
  assign bus.active_mask = active_q;
  assign bus.busy        = (state_q == ST_RUN);
  assign bus.all_done    = (state_q == ST_DONE);

endmodule
